sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences every access to the cartridge's shared 32 KB SRAM.
- Arbitrates the SRAM between two requesters:
  - the Atari cartridge bus: time-critical, tied to the fi2 high phase;
  - the microcontroller byte port: opportunistic, tied to the fi2 low phase.
- Drives the SRAM control strobes and the address/data mux, and returns read data and completion handshakes to both sides.
- Sits between the cartridge bus decode logic, the microcontroller interface and the SRAM pins.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 8, SRAM data width.
- CYCLE_LEN, 4, clk cycles per SRAM access; legal range 3..8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fi2  input  1  raw Atari phi2; asynchronous, synchronised internally.
- cart_rd_req  input  1  decoded cart read request; level, sampled on the fi2 rising-edge detect.
- cart_wr_req  input  1  decoded cart write request (write-enable already applied); same sampling as cart_rd_req.
- cart_addr  input  ADDR_W  cart-side SRAM address; held stable through the fi2 high phase.
- cart_wdata  input  DATA_W  cart write data.
- cart_rdata  output  DATA_W  latched cart read data; held until the next cart read.
- cart_done  output  1  one-clk pulse on the final clk of a cart cycle.
- uc_req  input  1  microcontroller request; 4-phase handshake.
- uc_we  input  1  1 = write, 0 = read; valid while uc_req = 1.
- uc_addr  input  ADDR_W  microcontroller SRAM address.
- uc_wdata  input  DATA_W  microcontroller write data.
- uc_rdata  output  DATA_W  latched microcontroller read data.
- uc_ack  output  1  handshake acknowledge.
- ram_addr  output  ADDR_W  SRAM address.
- ram_dout  output  DATA_W  SRAM write data.
- ram_drive  output  1  1 = enable ram_dout onto the SRAM data pins.
- ram_din  input  DATA_W  SRAM read data.
- ram_oe_n  output  1  SRAM output enable, active low.
- ram_we_n  output  1  SRAM write enable, active low.
- overlap_err  output  1  sticky flag: a cart edge arrived while a uc cycle was in progress.

Behaviour:
- Reset (asynchronous, immediate, including mid-cycle):
  - state = IDLE, phase = 0;
  - ram_oe_n = 1, ram_we_n = 1, ram_drive = 0;
  - uc_ack = 0, cart_done = 0, overlap_err = 0;
  - cart_rdata = 0, uc_rdata = 0, ram_addr = 0;
  - synchroniser flops = 0, cart_pending = 0.
- fi2 synchronisation: 2-flop synchroniser plus one history flop.
  - rise = pulse when history = 0 and current = 1.
  - fall = pulse when history = 1 and current = 0.
- States: IDLE, CART_RD, CART_WR, UC_RD, UC_WR. Phase counter runs 0..CYCLE_LEN-1 in every non-IDLE state.
- IDLE transitions, in priority order:
  1. rise & cart_wr_req -> CART_WR.
  2. rise & cart_rd_req -> CART_RD.
  3. cart_pending & pending_we -> CART_WR; cart_pending & ~pending_we -> CART_RD; either clears cart_pending.
  4. fall & uc_req & ~uc_ack -> UC_WR if uc_we, else UC_RD.
  - cart_wr_req and cart_rd_req both high: write wins.
- Address/data capture:
  - On entry, ram_addr latches the selected requester's address.
  - For writes, ram_dout latches the selected write data.
  - Both are held constant for the whole access.
- Strobes during an access:
  - Read: ram_oe_n = 0 for all phases.
  - Write: ram_drive = 1 for all phases; ram_we_n = 0 only for phase 1..CYCLE_LEN-2, giving address setup and hold of 1 clk each.
- Read data: ram_din is latched into cart_rdata or uc_rdata at phase CYCLE_LEN-2.
- Completion at phase CYCLE_LEN-1:
  - cart states pulse cart_done;
  - uc states set uc_ack;
  - next clk: state = IDLE, phase = 0, all strobes inactive.
- Cart latency: rise detect to first strobe clk = 1 clk; total fi2-edge-to-done = 3 + CYCLE_LEN clk.
- uc handshake:
  - uc_ack stays 1 until uc_req is seen low, then clears on the next clk.
  - No new uc cycle starts while uc_ack = 1, so one request gives exactly one access.
  - uc_req dropping mid-cycle does not abort the access; uc_ack still pulses for one clk after completion.
- Collision (rise while in UC_RD/UC_WR):
  - the uc cycle completes normally;
  - the cart request is captured into cart_pending/pending_we, with address and data sampled at rise;
  - overlap_err is set; it clears only on reset.
  - The pending cart cycle starts on the clk after the uc cycle returns to IDLE, ahead of any uc request.
- A rise with no cart request is ignored. A fall with no uc request is ignored.

Test Plan:
- Cart read, CYCLE_LEN=4: SRAM[0x1234]=0xA5; fi2 rises with cart_rd_req=1, cart_addr=0x1234 -> ram_oe_n low for 4 clk, cart_rdata=0xA5, cart_done pulses once, ram_we_n never low.
- Cart write: cart_wr_req=1, cart_addr=0x7FFF, cart_wdata=0x3C -> ram_we_n low exactly phases 1-2, ram_drive high 4 clk, SRAM[0x7FFF]=0x3C.
- uc handshake: uc_req=1, uc_we=0, uc_addr=0x0010 (SRAM=0x5A); held through two fi2 falls -> exactly one read, uc_rdata=0x5A, uc_ack high until uc_req drops, then 0 next clk.
- Simultaneous read and write requests: cart_rd_req=cart_wr_req=1 at rise -> CART_WR taken.
- Collision: uc write started, fi2 forced to rise at uc phase 1 with cart_rd_req=1 -> uc write completes, cart read starts the next clk after IDLE, overlap_err=1.
- Reset mid-write: reset_n low at phase 1 -> ram_we_n=1, ram_drive=0, uc_ack=0 immediately; after release the arbiter is IDLE and serves a new cart read correctly.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one SRAM between the fi2-high cart bus and the fi2-low uc byte port.
// Latency: cart 3 clk sync/decode + CYCLE_LEN access; uc starts 3 clk after fi2 fall. Backpressure: uc via 4-phase req/ack, cart deferred once.
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int CYCLE_LEN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fi2,
    input  logic              cart_rd_req,
    input  logic              cart_wr_req,
    input  logic [ADDR_W-1:0] cart_addr,
    input  logic [DATA_W-1:0] cart_wdata,
    output logic [DATA_W-1:0] cart_rdata,
    output logic              cart_done,
    input  logic              uc_req,
    input  logic              uc_we,
    input  logic [ADDR_W-1:0] uc_addr,
    input  logic [DATA_W-1:0] uc_wdata,
    output logic [DATA_W-1:0] uc_rdata,
    output logic              uc_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_drive,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              overlap_err
);
    localparam int PW = (CYCLE_LEN > 4) ? 3 : 2;
    localparam logic [PW-1:0] LAST    = PW'(CYCLE_LEN - 1);
    localparam logic [PW-1:0] RD_LAT  = PW'(CYCLE_LEN - 2);

    typedef enum logic [2:0] {S_IDLE, S_CART_RD, S_CART_WR, S_UC_RD, S_UC_WR} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_phase;
    logic              r_fi2_s1, r_fi2_s2, r_fi2_h;
    logic              r_cart_pending, r_pending_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_wdata;

    logic          w_rise, w_fall, w_cart_req, w_uc_busy, w_is_wr, w_is_cart;
    logic [PW-1:0] w_phase_nxt;

    assign w_rise      = r_fi2_s2 & ~r_fi2_h;
    assign w_fall      = ~r_fi2_s2 & r_fi2_h;
    assign w_cart_req  = cart_rd_req | cart_wr_req;
    assign w_uc_busy   = (r_state == S_UC_RD) || (r_state == S_UC_WR);
    assign w_is_wr     = (r_state == S_CART_WR) || (r_state == S_UC_WR);
    assign w_is_cart   = (r_state == S_CART_RD) || (r_state == S_CART_WR);
    assign w_phase_nxt = r_phase + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_fi2_s1       <= 1'b0;
            r_fi2_s2       <= 1'b0;
            r_fi2_h        <= 1'b0;
            r_cart_pending <= 1'b0;
            r_pending_we   <= 1'b0;
            r_pend_addr    <= '0;
            r_pend_wdata   <= '0;
            ram_oe_n       <= 1'b1;
            ram_we_n       <= 1'b1;
            ram_drive      <= 1'b0;
            ram_addr       <= '0;
            ram_dout       <= '0;
            uc_ack         <= 1'b0;
            cart_done      <= 1'b0;
            overlap_err    <= 1'b0;
            cart_rdata     <= '0;
            uc_rdata       <= '0;
        end else begin
            r_fi2_s1  <= fi2;
            r_fi2_s2  <= r_fi2_s1;
            r_fi2_h   <= r_fi2_s2;
            cart_done <= 1'b0;
            if (uc_ack && !uc_req)
                uc_ack <= 1'b0;

            if (r_state == S_IDLE) begin
                r_phase <= '0;
                if (w_rise && cart_wr_req) begin
                    r_state   <= S_CART_WR;
                    ram_addr  <= cart_addr;
                    ram_dout  <= cart_wdata;
                    ram_drive <= 1'b1;
                end else if (w_rise && cart_rd_req) begin
                    r_state  <= S_CART_RD;
                    ram_addr <= cart_addr;
                    ram_oe_n <= 1'b0;
                end else if (r_cart_pending) begin
                    r_cart_pending <= 1'b0;
                    ram_addr       <= r_pend_addr;
                    if (r_pending_we) begin
                        r_state   <= S_CART_WR;
                        ram_dout  <= r_pend_wdata;
                        ram_drive <= 1'b1;
                    end else begin
                        r_state  <= S_CART_RD;
                        ram_oe_n <= 1'b0;
                    end
                end else if (w_fall && uc_req && !uc_ack) begin
                    ram_addr <= uc_addr;
                    if (uc_we) begin
                        r_state   <= S_UC_WR;
                        ram_dout  <= uc_wdata;
                        ram_drive <= 1'b1;
                    end else begin
                        r_state  <= S_UC_RD;
                        ram_oe_n <= 1'b0;
                    end
                end
            end else begin
                // A cart edge during a uc access is deferred, not dropped.
                if (w_rise && w_cart_req && w_uc_busy) begin
                    r_cart_pending <= 1'b1;
                    r_pending_we   <= cart_wr_req;
                    r_pend_addr    <= cart_addr;
                    r_pend_wdata   <= cart_wdata;
                    overlap_err    <= 1'b1;
                end
                if (r_phase == LAST) begin
                    r_state   <= S_IDLE;
                    r_phase   <= '0;
                    ram_oe_n  <= 1'b1;
                    ram_we_n  <= 1'b1;
                    ram_drive <= 1'b0;
                end else begin
                    r_phase <= w_phase_nxt;
                    if (w_is_wr)
                        ram_we_n <= (w_phase_nxt == LAST);
                    if (!w_is_wr && r_phase == RD_LAT) begin
                        if (w_is_cart)
                            cart_rdata <= ram_din;
                        else
                            uc_rdata <= ram_din;
                    end
                    if (w_phase_nxt == LAST) begin
                        if (w_is_cart)
                            cart_done <= 1'b1;
                        else
                            uc_ack <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 32 KB SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        fi2;
    logic        cart_rd_req, cart_wr_req;
    logic [14:0] cart_addr;
    logic [7:0]  cart_wdata, cart_rdata;
    logic        cart_done;
    logic        uc_req, uc_we;
    logic [14:0] uc_addr;
    logic [7:0]  uc_wdata, uc_rdata;
    logic        uc_ack;
    logic [14:0] ram_addr;
    logic [7:0]  ram_dout, ram_din;
    logic        ram_drive, ram_oe_n, ram_we_n, overlap_err;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mem [0:32767];
    int n_oe = 0, n_we = 0, n_drv = 0, n_done = 0, cyc = 0;
    int last_drv_cyc = 0, oe_start_cyc = 0;
    logic [3:0] we_pat = 4'hF;
    logic prev_oe_n = 1'b1;
    int b_oe, b_we, b_drv, b_done;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(15), .DATA_W(8), .CYCLE_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .fi2(fi2),
        .cart_rd_req(cart_rd_req), .cart_wr_req(cart_wr_req),
        .cart_addr(cart_addr), .cart_wdata(cart_wdata),
        .cart_rdata(cart_rdata), .cart_done(cart_done),
        .uc_req(uc_req), .uc_we(uc_we), .uc_addr(uc_addr),
        .uc_wdata(uc_wdata), .uc_rdata(uc_rdata), .uc_ack(uc_ack),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_drive(ram_drive),
        .ram_din(ram_din), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .overlap_err(overlap_err)
    );

    assign ram_din = mem[ram_addr];

    // SRAM model and strobe monitor, both sampled on the falling edge.
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h1234] = 8'hA5;
        mem[15'h0010] = 8'h5A;
        mem[15'h0100] = 8'h11;
        mem[15'h0300] = 8'h96;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if (!ram_we_n && ram_drive) mem[ram_addr] = ram_dout;
                if (!ram_oe_n) n_oe++;
                if (!ram_oe_n && prev_oe_n) oe_start_cyc = cyc;
                if (!ram_we_n) n_we++;
                if (ram_drive) begin
                    n_drv++;
                    last_drv_cyc = cyc;
                    we_pat = {we_pat[2:0], ram_we_n};
                end
                if (cart_done) n_done++;
            end
            prev_oe_n = ram_oe_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_oe = n_oe; b_we = n_we; b_drv = n_drv; b_done = n_done;
    endtask

    initial begin
        reset_n = 1'b0; fi2 = 1'b0;
        cart_rd_req = 1'b0; cart_wr_req = 1'b0; cart_addr = '0; cart_wdata = '0;
        uc_req = 1'b0; uc_we = 1'b0; uc_addr = '0; uc_wdata = '0;
        tick(2);
        check("rst_oe_n", ram_oe_n, 1);
        check("rst_we_n", ram_we_n, 1);
        check("rst_drive", ram_drive, 0);
        check("rst_ack", uc_ack, 0);
        check("rst_addr", ram_addr, 0);
        reset_n = 1'b1;
        tick(2);

        // Cart read
        snap();
        cart_rd_req = 1'b1; cart_addr = 15'h1234; fi2 = 1'b1;
        tick(10);
        check("crd_data", cart_rdata, 8'hA5);
        check("crd_oe_cnt", n_oe - b_oe, 4);
        check("crd_we_cnt", n_we - b_we, 0);
        check("crd_done", n_done - b_done, 1);
        cart_rd_req = 1'b0; fi2 = 1'b0;
        tick(6);

        // Cart write
        snap();
        cart_wr_req = 1'b1; cart_addr = 15'h7FFF; cart_wdata = 8'h3C; fi2 = 1'b1;
        tick(10);
        check("cwr_mem", mem[15'h7FFF], 8'h3C);
        check("cwr_we_cnt", n_we - b_we, 2);
        check("cwr_drv_cnt", n_drv - b_drv, 4);
        check("cwr_we_pat", we_pat, 4'b1001);
        check("cwr_done", n_done - b_done, 1);
        cart_wr_req = 1'b0; fi2 = 1'b0;
        tick(6);

        // Read and write together: write wins
        snap();
        cart_rd_req = 1'b1; cart_wr_req = 1'b1; cart_addr = 15'h0100; cart_wdata = 8'h77; fi2 = 1'b1;
        tick(10);
        check("both_mem", mem[15'h0100], 8'h77);
        check("both_oe_cnt", n_oe - b_oe, 0);
        check("both_drv_cnt", n_drv - b_drv, 4);
        cart_rd_req = 1'b0; cart_wr_req = 1'b0;
        tick(4);

        // uc read held across two fi2 falls
        snap();
        uc_req = 1'b1; uc_we = 1'b0; uc_addr = 15'h0010; fi2 = 1'b0;
        tick(8);
        check("uc_rdata", uc_rdata, 8'h5A);
        check("uc_ack_hi", uc_ack, 1);
        fi2 = 1'b1;
        tick(4);
        fi2 = 1'b0;
        tick(8);
        check("uc_one_acc", n_oe - b_oe, 4);
        check("uc_ack_held", uc_ack, 1);
        uc_req = 1'b0;
        check("uc_ack_still", uc_ack, 1);
        tick(1);
        check("uc_ack_clr", uc_ack, 0);
        check("no_overlap", overlap_err, 0);

        // Collision: cart read edge while uc write is running
        fi2 = 1'b1;
        tick(4);
        snap();
        uc_req = 1'b1; uc_we = 1'b1; uc_addr = 15'h0200; uc_wdata = 8'hC3;
        cart_addr = 15'h0300; fi2 = 1'b0;
        tick(1);
        fi2 = 1'b1; cart_rd_req = 1'b1;
        tick(14);
        check("col_uc_mem", mem[15'h0200], 8'hC3);
        check("col_cart_data", cart_rdata, 8'h96);
        check("col_overlap", overlap_err, 1);
        check("col_drv_cnt", n_drv - b_drv, 4);
        check("col_oe_cnt", n_oe - b_oe, 4);
        check("col_gap", oe_start_cyc - last_drv_cyc, 2);
        check("col_done", n_done - b_done, 1);
        uc_req = 1'b0; cart_rd_req = 1'b0;
        tick(3);

        // Reset in the middle of a uc write
        uc_req = 1'b1; uc_we = 1'b1; uc_addr = 15'h0400; uc_wdata = 8'hEE; fi2 = 1'b0;
        tick(4);
        check("mid_we_low", ram_we_n, 0);
        reset_n = 1'b0;
        #1;
        check("mrst_we_n", ram_we_n, 1);
        check("mrst_drive", ram_drive, 0);
        check("mrst_ack", uc_ack, 0);
        check("mrst_overlap", overlap_err, 0);
        check("mrst_rdata", cart_rdata, 0);
        uc_req = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        snap();
        cart_rd_req = 1'b1; cart_addr = 15'h1234; fi2 = 1'b1;
        tick(10);
        check("post_data", cart_rdata, 8'hA5);
        check("post_oe_cnt", n_oe - b_oe, 4);
        check("post_done", n_done - b_done, 1);
        check("post_mem400", mem[15'h0400], 8'h00);
        cart_rd_req = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
